// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry registered buffer of {data, last}; the head entry drives the stream outputs from flops.
module fifo_stream_reader_skid
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } entry_t;

  entry_t           head_q, tail_q, new_entry;
  logic [CNT_W-1:0] count_q;
  logic             pop;

  assign new_entry = '{data: push_data, last: push_last};
  assign pop       = out_valid && out_ready;

  // The caller only pushes into a full buffer when a pop frees the head in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == CNT_W'(0)) head_q <= new_entry;
          else                      tail_q <= new_entry;
          count_q <= count_q + CNT_W'(1);
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            head_q <= new_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (count_q != CNT_W'(0));
  assign out_data  = head_q.data;
  assign out_last  = head_q.last;
  assign count     = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine: pops a synchronous FIFO and re-emits words as a registered
// valid/ready stream with optional fixed-length burst framing.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] beat_q, beat_d, len_q, cur_len;
  logic [CNT_W-1:0] count;
  logic             last_tag;

  // burst_len is only looked at on the first beat; later beats use the latched copy.
  assign cur_len  = (beat_q == '0) ? burst_len : len_q;
  assign last_tag = (cur_len != '0) && (beat_q == cur_len - LEN_W'(1));

  assign fifo_read = (state_q != IDLE) && !fifo_empty &&
                     ((count < CNT_W'(BUF_DEPTH)) || (out_valid && out_ready));

  always_comb begin
    beat_d = beat_q;
    if (fifo_read) begin
      if ((cur_len == '0) || last_tag) beat_d = '0;
      else                             beat_d = beat_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (fifo_read) len_q <= cur_len;
    end
  end

  // Leaving ACTIVE looks at the post-capture beat so a burst started this cycle is still completed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!enable) state_d = (beat_d == '0) ? IDLE : FINISH;
      end
      FINISH: begin
        if (enable)               state_d = ACTIVE;
        else if (beat_d == '0)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE) || (count != CNT_W'(0));

  fifo_stream_reader_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_read),
    .push_data (fifo_data),
    .push_last (last_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (count)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO and an output monitor.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] burst_len;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  logic [7:0] mem [0:31];
  logic [5:0] rd_ptr = '0;
  logic [5:0] wr_ptr = '0;
  int         violations = 0;
  logic [7:0] mon_data [$];
  logic       mon_last [$];

  int errors = 0;
  int checks = 0;

  fifo_stream_reader #(.WIDTH(8), .LEN_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .burst_len  (burst_len),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr[4:0]];

  always @(posedge clk) begin
    if (fifo_read) rd_ptr <= rd_ptr + 6'd1;
    if (!reset && out_valid && out_ready) begin
      mon_data.push_back(out_data);
      mon_last.push_back(out_last);
    end
  end

  always @(negedge clk) begin
    if (fifo_read && fifo_empty) violations++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] len, input logic rdy);
    enable    = en;
    burst_len = len;
    out_ready = rdy;
  endtask

  task automatic pushWord(input logic [7:0] w);
    mem[wr_ptr[4:0]] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic waitWords(input int n, input int limit);
    int k;
    k = 0;
    while (mon_data.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    checkOutput("word_count", 32'(mon_data.size()), 32'(n));
  endtask

  initial begin
    int         base;
    logic [5:0] start;
    logic [7:0] exp_b [8];

    reset = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_fifo_read", 32'(fifo_read), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data",  32'(out_data),  0);
    checkOutput("rst_out_last",  32'(out_last),  0);
    checkOutput("rst_busy",      32'(busy),      0);
    reset = 1'b0;
    @(negedge clk);

    // Unframed: three words, back to back.
    pushWord(8'h11); pushWord(8'h22); pushWord(8'h33);
    base = mon_data.size();
    applyStimulus(1'b1, 4'd0, 1'b1);
    @(negedge clk);
    checkOutput("a_n1_read",  32'(fifo_read), 1);
    checkOutput("a_n1_valid", 32'(out_valid), 0);
    @(negedge clk);
    checkOutput("a_n2_read",  32'(fifo_read), 1);
    checkOutput("a_n2_data",  32'({out_valid, out_last, out_data}), 32'h211);
    @(negedge clk);
    checkOutput("a_n3_read",  32'(fifo_read), 1);
    checkOutput("a_n3_data",  32'({out_valid, out_last, out_data}), 32'h222);
    @(negedge clk);
    checkOutput("a_n4_read",  32'(fifo_read), 0);
    checkOutput("a_n4_data",  32'({out_valid, out_last, out_data}), 32'h233);
    @(negedge clk);
    checkOutput("a_n5_valid", 32'(out_valid), 0);
    checkOutput("a_words",    32'(mon_data.size() - base), 3);
    applyStimulus(1'b0, 4'd0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("a_idle_busy", 32'(busy), 0);

    // burst_len = 4 over eight words: last on 0x03 and 0x07.
    for (int i = 0; i < 8; i++) pushWord(8'(i));
    exp_b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    base = mon_data.size();
    applyStimulus(1'b1, 4'd4, 1'b1);
    waitWords(base + 8, 40);
    for (int i = 0; i < 8; i++) begin
      if (base + i < mon_data.size()) begin
        checkOutput($sformatf("b_data%0d", i), 32'(mon_data[base + i]), 32'(exp_b[i]));
        checkOutput($sformatf("b_last%0d", i), 32'(mon_last[base + i]), (i == 3 || i == 7) ? 1 : 0);
      end
    end
    applyStimulus(1'b0, 4'd4, 1'b1);
    repeat (2) @(negedge clk);

    // Backpressure: buffer fills with two words, pops stop, head stays put.
    for (int i = 0; i < 4; i++) pushWord(8'(i));
    start = rd_ptr;
    base  = mon_data.size();
    applyStimulus(1'b1, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("c_n3_read", 32'(fifo_read), 0);
    checkOutput("c_n3_data", 32'({out_valid, out_data}), 32'h100);
    repeat (2) @(negedge clk);
    checkOutput("c_pops",    32'(6'(rd_ptr - start)), 2);
    checkOutput("c_n5_read", 32'(fifo_read), 0);
    checkOutput("c_n5_data", 32'({out_valid, out_data}), 32'h100);
    applyStimulus(1'b1, 4'd0, 1'b1);
    waitWords(base + 4, 20);
    for (int i = 0; i < 4; i++)
      if (base + i < mon_data.size())
        checkOutput($sformatf("c_order%0d", i), 32'(mon_data[base + i]), 32'(i));
    checkOutput("c_total_pops", 32'(6'(rd_ptr - start)), 4);
    applyStimulus(1'b0, 4'd0, 1'b1);
    repeat (2) @(negedge clk);

    // Drop enable mid-burst: the burst completes, then no further pops.
    for (int i = 0; i < 6; i++) pushWord(8'hA0 + 8'(i));
    start = rd_ptr;
    base  = mon_data.size();
    applyStimulus(1'b1, 4'd4, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 4'd4, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("d_pops",  32'(6'(rd_ptr - start)), 4);
    checkOutput("d_read",  32'(fifo_read), 0);
    checkOutput("d_busy",  32'(busy), 0);
    checkOutput("d_words", 32'(mon_data.size() - base), 4);
    if (mon_data.size() >= base + 4) begin
      checkOutput("d_w3_data", 32'(mon_data[base + 3]), 32'hA3);
      checkOutput("d_w3_last", 32'(mon_last[base + 3]), 1);
      checkOutput("d_w2_last", 32'(mon_last[base + 2]), 0);
    end
    base = mon_data.size();
    applyStimulus(1'b1, 4'd2, 1'b1);
    waitWords(base + 2, 20);
    if (mon_data.size() >= base + 2) begin
      checkOutput("d_r0", 32'({mon_last[base], mon_data[base]}), 32'h0A4);
      checkOutput("d_r1", 32'({mon_last[base + 1], mon_data[base + 1]}), 32'h1A5);
    end
    applyStimulus(1'b0, 4'd2, 1'b1);
    repeat (2) @(negedge clk);

    // FIFO runs dry mid-burst, then refills.
    pushWord(8'hB0); pushWord(8'hB1);
    start = rd_ptr;
    base  = mon_data.size();
    applyStimulus(1'b1, 4'd3, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("e_pops",  32'(6'(rd_ptr - start)), 2);
    checkOutput("e_busy",  32'(busy), 1);
    checkOutput("e_valid", 32'(out_valid), 0);
    pushWord(8'hB2);
    waitWords(base + 3, 20);
    if (mon_data.size() >= base + 3) begin
      checkOutput("e_w0", 32'({mon_last[base], mon_data[base]}), 32'h0B0);
      checkOutput("e_w1", 32'({mon_last[base + 1], mon_data[base + 1]}), 32'h0B1);
      checkOutput("e_w2", 32'({mon_last[base + 2], mon_data[base + 2]}), 32'h1B2);
    end
    applyStimulus(1'b0, 4'd3, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("e_idle_busy", 32'(busy), 0);

    // Reset with two words buffered.
    for (int i = 0; i < 4; i++) pushWord(8'hC0 + 8'(i));
    applyStimulus(1'b1, 4'd0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("f_pre_valid", 32'(out_valid), 1);
    reset = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("f_rst_valid", 32'(out_valid), 0);
    checkOutput("f_rst_read",  32'(fifo_read), 0);
    checkOutput("f_rst_busy",  32'(busy), 0);
    start = rd_ptr;
    repeat (3) @(negedge clk);
    checkOutput("f_rst_ptr", 32'(rd_ptr), 32'(start));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("f_post_ptr",   32'(rd_ptr), 32'(start));
    checkOutput("f_post_valid", 32'(out_valid), 0);

    checkOutput("no_read_when_empty", 32'(violations), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
